// File: rtl/fsm_lab_pkg.sv
// +------------------------------------------------------------------+
// | Package : fsm_lab_pkg                                            |
// | Shared state encodings and defaults for the pattern transmitter. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package fsm_lab_pkg;

  localparam int STATE_W      = 3;
  localparam int BIT_INDEX_W  = 5;
  localparam int SENT_COUNT_W = 6;

  localparam int                           DEFAULT_PATTERN_LEN = 27;
  localparam logic [DEFAULT_PATTERN_LEN-1:0] DEFAULT_PATTERN   = 27'b010101001111011011110110001;

  // Gray-style walk so only one bit changes per phase step.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'b000,
    S_SETUP  = 3'b001,
    S_PRE    = 3'b011,
    S_STROBE = 3'b010,
    S_POST   = 3'b110
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_pattern_tx_if.sv
// +------------------------------------------------------------------+
// | Interface : seq_pattern_tx_if                                    |
// | Control and serial-output bundle of the pattern transmitter.     |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

interface seq_pattern_tx_if;
  import fsm_lab_pkg::*;

  logic                    start;
  logic                    repeat_en;
  logic                    abort;
  logic                    switch0;
  logic                    key1;
  logic                    busy;
  logic                    done;
  logic [BIT_INDEX_W-1:0]  bit_index;
  logic [SENT_COUNT_W-1:0] sent_count;
  logic [STATE_W-1:0]      current_state;

  modport master (
    output start, repeat_en, abort,
    input  switch0, key1, busy, done, bit_index, sent_count, current_state
  );

  modport slave (
    input  start, repeat_en, abort,
    output switch0, key1, busy, done, bit_index, sent_count, current_state
  );

endinterface

`default_nettype wire

// File: rtl/seq_pattern_tx_phase_timer.sv
// +------------------------------------------------------------------+
// | Module  : phase_timer                                            |
// | Load/decrement phase counter with terminal-count flag.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module phase_timer #(
  parameter int PHASE_CYCLES = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic tc
);

  localparam int                 C_W    = $clog2(PHASE_CYCLES + 1);
  localparam logic [C_W-1:0]     c_load = C_W'(PHASE_CYCLES - 1);

  logic [C_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset || load) begin
      r_count <= c_load;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// +------------------------------------------------------------------+
// | Module  : seq_pattern_tx                                         |
// | Plays a stored bit pattern as switch0 data framed by key1.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module seq_pattern_tx
  import fsm_lab_pkg::*;
#(
  parameter int                     PATTERN_LEN  = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN      = DEFAULT_PATTERN,
  parameter int                     PHASE_CYCLES = 5
) (
  input  logic            clock,
  input  logic            reset,
  seq_pattern_tx_if.slave bus
);

  localparam logic [BIT_INDEX_W-1:0] c_last    = BIT_INDEX_W'(PATTERN_LEN - 1);
  localparam logic [31:0]            c_pattern = 32'(PATTERN);

  state_t                  r_state, w_state_next;
  logic [BIT_INDEX_W-1:0]  r_bit_index, w_bit_index_next;
  logic [SENT_COUNT_W-1:0] r_sent_count, w_sent_count_next;
  logic                    r_switch0, w_switch0_next;
  logic                    r_key1, r_busy, r_done, w_done_next;
  logic                    w_load, w_tc;

  phase_timer #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phase_timer (
    .clock (clock),
    .reset (reset),
    .load  (w_load),
    .tc    (w_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_bit_index  <= c_last;
      r_sent_count <= '0;
      r_switch0    <= 1'b0;
      r_key1       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bit_index  <= w_bit_index_next;
      r_sent_count <= w_sent_count_next;
      r_switch0    <= w_switch0_next;
      r_key1       <= (w_state_next == S_STROBE);
      r_busy       <= (w_state_next != S_IDLE);
      r_done       <= w_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_bit_index_next  = r_bit_index;
    w_sent_count_next = r_sent_count;
    w_switch0_next    = r_switch0;
    w_done_next       = 1'b0;
    w_load            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next   = S_SETUP;
          w_switch0_next = c_pattern[r_bit_index];
          w_load         = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_tc) begin
          w_state_next = S_PRE;
          w_load       = 1'b1;
        end
      end
      S_PRE: begin
        if (w_tc) begin
          w_state_next = S_STROBE;
          w_load       = 1'b1;
        end
      end
      S_STROBE: begin
        if (w_tc) begin
          w_state_next = S_POST;
          w_load       = 1'b1;
        end
      end
      S_POST: begin
        if (w_tc) begin
          w_sent_count_next = r_sent_count + 1'b1;
          if (r_bit_index != '0) begin
            w_bit_index_next = r_bit_index - 1'b1;
            w_state_next     = S_SETUP;
            w_switch0_next   = c_pattern[r_bit_index - 1'b1];
            w_load           = 1'b1;
          end else begin
            w_done_next      = 1'b1;
            w_bit_index_next = c_last;
            if (bus.repeat_en) begin
              w_state_next   = S_SETUP;
              w_switch0_next = c_pattern[c_last];
              w_load         = 1'b1;
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_bit_index_next = c_last;
      end
    endcase

    // Abort overrides everything, including a start or a frame completion this cycle.
    if (bus.abort) begin
      w_state_next      = S_IDLE;
      w_bit_index_next  = c_last;
      w_sent_count_next = r_sent_count;
      w_switch0_next    = r_switch0;
      w_done_next       = 1'b0;
      w_load            = 1'b0;
    end
  end

  assign bus.switch0       = r_switch0;
  assign bus.key1          = r_key1;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.bit_index     = r_bit_index;
  assign bus.sent_count    = r_sent_count;
  assign bus.current_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// +------------------------------------------------------------------+
// | Module  : tb_seq_pattern_tx                                      |
// | Directed bench for the default and the minimal configuration.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_seq_pattern_tx;

  localparam logic [26:0] c_pat = 27'b010101001111011011110110001;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  seq_pattern_tx_if bus ();
  seq_pattern_tx_if bus2 ();

  seq_pattern_tx u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  seq_pattern_tx #(
    .PATTERN_LEN  (1),
    .PATTERN      (1'b1),
    .PHASE_CYCLES (1)
  ) u_dut_min (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    if ({bus.switch0, bus.key1, bus.busy, bus.done} !== 4'b0) begin
      $display("FAIL reset_outputs got %b want 0000", {bus.switch0, bus.key1, bus.busy, bus.done}); n_err++;
    end
    n_cmp++;
    if (bus.current_state !== 3'b000 || bus.sent_count !== 6'd0) begin
      $display("FAIL reset_state got %0d/%0d want 0/0", bus.current_state, bus.sent_count); n_err++;
    end
    n_cmp++;
    if (bus.bit_index !== 5'd26) begin
      $display("FAIL reset_bit_index got %0d want 26", bus.bit_index); n_err++;
    end
    n_cmp++;
    if (bus2.bit_index !== 5'd0 || bus2.current_state !== 3'b000) begin
      $display("FAIL reset_min got %0d/%0d want 0/0", bus2.bit_index, bus2.current_state); n_err++;
    end
    n_cmp++;
    reset = 1'b1;
    repeat (5) step();
    if (bus.current_state !== 3'b000 || bus.busy !== 1'b0) begin
      $display("FAIL idle_hold got %0d/%0d want 0/0", bus.current_state, bus.busy); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_single_pass();
    int bad_key, bad_sw, bad_st, bad_done, pulses;
    logic [2:0] exp_st;
    int ph, fr;
    bad_key = 0; bad_sw = 0; bad_st = 0; bad_done = 0; pulses = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (bus.current_state !== 3'b001 || bus.busy !== 1'b1 || bus.switch0 !== 1'b0) begin
      $display("FAIL start_entry got st=%0d busy=%0d sw=%0d want 1/1/0", bus.current_state, bus.busy, bus.switch0); n_err++;
    end
    n_cmp++;
    for (int c = 1; c <= 541; c++) begin
      step();
      ph = c % 20;
      fr = c / 20;
      if (c < 540) begin
        exp_st = (ph < 5) ? 3'b001 : (ph < 10) ? 3'b011 : (ph < 15) ? 3'b010 : 3'b110;
        if (bus.current_state !== exp_st) bad_st++;
        if (bus.key1 !== (ph >= 10 && ph < 15)) bad_key++;
        if (bus.switch0 !== c_pat[26 - fr]) bad_sw++;
        if (bus.bit_index !== 5'(26 - fr)) bad_st++;
      end
      if (bus.done !== (c == 540)) bad_done++;
      if (bus.key1 === 1'b1 && ph == 10) pulses++;
      if (c == 220) begin
        if (pulses != 11 || bus.sent_count !== 6'd11) begin
          $display("FAIL pulses_220 got %0d/%0d want 11/11", pulses, bus.sent_count); n_err++;
        end
        n_cmp++;
      end
      if (c == 540) begin
        if (bus.current_state !== 3'b000 || bus.busy !== 1'b0 || bus.key1 !== 1'b0) begin
          $display("FAIL pass_end got st=%0d busy=%0d want 0/0", bus.current_state, bus.busy); n_err++;
        end
        n_cmp++;
        if (bus.sent_count !== 6'd27 || bus.bit_index !== 5'd26 || bus.switch0 !== 1'b1) begin
          $display("FAIL pass_regs got cnt=%0d idx=%0d sw=%0d want 27/26/1", bus.sent_count, bus.bit_index, bus.switch0); n_err++;
        end
        n_cmp++;
      end
    end
    if (bad_st != 0) begin $display("FAIL frame_state got %0d bad cycles want 0", bad_st); n_err++; end
    n_cmp++;
    if (bad_key != 0) begin $display("FAIL key1_window got %0d bad cycles want 0", bad_key); n_err++; end
    n_cmp++;
    if (bad_sw != 0) begin $display("FAIL switch0_bits got %0d bad cycles want 0", bad_sw); n_err++; end
    n_cmp++;
    if (bad_done != 0) begin $display("FAIL done_pulse got %0d bad cycles want 0", bad_done); n_err++; end
    n_cmp++;
  endtask

  task automatic test_repeat();
    int idle_seen, bad_done;
    idle_seen = 0; bad_done = 0;
    bus.repeat_en = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 1080; c++) begin
      step();
      if (bus.current_state === 3'b000) idle_seen++;
      if (bus.done !== (c == 540 || c == 1080)) bad_done++;
      if (c == 540) begin
        if (bus.current_state !== 3'b001 || bus.switch0 !== c_pat[26] || bus.bit_index !== 5'd26) begin
          $display("FAIL repeat_wrap got st=%0d sw=%0d idx=%0d want 1/0/26", bus.current_state, bus.switch0, bus.bit_index); n_err++;
        end
        n_cmp++;
      end
    end
    if (idle_seen != 0) begin $display("FAIL repeat_no_idle got %0d idle cycles want 0", idle_seen); n_err++; end
    n_cmp++;
    if (bad_done != 0) begin $display("FAIL repeat_done got %0d bad cycles want 0", bad_done); n_err++; end
    n_cmp++;
    // 27 from the first pass plus 54 more frames, modulo 64.
    if (bus.sent_count !== 6'd17) begin $display("FAIL repeat_count got %0d want 17", bus.sent_count); n_err++; end
    n_cmp++;
    bus.repeat_en = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    if (bus.current_state !== 3'b000 || bus.sent_count !== 6'd17) begin
      $display("FAIL abort_keeps_count got st=%0d cnt=%0d want 0/17", bus.current_state, bus.sent_count); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_abort();
    reset = 1'b0;
    step();
    reset = 1'b1;
    if (bus.sent_count !== 6'd0) begin $display("FAIL reset_clears_count got %0d want 0", bus.sent_count); n_err++; end
    n_cmp++;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (11) step();
    if (bus.key1 !== 1'b1) begin $display("FAIL strobe_before_abort got %0d want 1", bus.key1); n_err++; end
    n_cmp++;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    if ({bus.key1, bus.busy, bus.done, bus.current_state} !== 6'b0 || bus.bit_index !== 5'd26 || bus.sent_count !== 6'd0) begin
      $display("FAIL abort_mid_strobe got k=%0d b=%0d st=%0d idx=%0d cnt=%0d want 0/0/0/26/0",
               bus.key1, bus.busy, bus.current_state, bus.bit_index, bus.sent_count); n_err++;
    end
    n_cmp++;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    if (bus.current_state !== 3'b000) begin $display("FAIL abort_beats_start got %0d want 0", bus.current_state); n_err++; end
    n_cmp++;
    step();
    bus.start = 1'b0;
    if (bus.current_state !== 3'b001 || bus.switch0 !== c_pat[26] || bus.bit_index !== 5'd26) begin
      $display("FAIL restart got st=%0d sw=%0d idx=%0d want 1/0/26", bus.current_state, bus.switch0, bus.bit_index); n_err++;
    end
    n_cmp++;
    step();
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    if (bus.current_state !== 3'b011) begin $display("FAIL start_while_busy got %0d want 3", bus.current_state); n_err++; end
    n_cmp++;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask

  task automatic test_min_config();
    int bad_key, bad_done, bad_cnt;
    bad_key = 0; bad_done = 0; bad_cnt = 0;
    bus2.repeat_en = 1'b1;
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    if (bus2.current_state !== 3'b001 || bus2.switch0 !== 1'b1) begin
      $display("FAIL min_entry got st=%0d sw=%0d want 1/1", bus2.current_state, bus2.switch0); n_err++;
    end
    n_cmp++;
    for (int c = 1; c <= 260; c++) begin
      step();
      if (bus2.key1 !== (c % 4 == 2)) bad_key++;
      if (bus2.done !== (c % 4 == 0)) bad_done++;
      if (bus2.sent_count !== 6'((c / 4) % 64) || bus2.bit_index !== 5'd0) bad_cnt++;
      if (c == 256) begin
        if (bus2.sent_count !== 6'd0 || bus2.done !== 1'b1) begin
          $display("FAIL min_wrap got cnt=%0d done=%0d want 0/1", bus2.sent_count, bus2.done); n_err++;
        end
        n_cmp++;
      end
    end
    if (bad_key != 0) begin $display("FAIL min_key1 got %0d bad cycles want 0", bad_key); n_err++; end
    n_cmp++;
    if (bad_done != 0) begin $display("FAIL min_done got %0d bad cycles want 0", bad_done); n_err++; end
    n_cmp++;
    if (bad_cnt != 0) begin $display("FAIL min_count got %0d bad cycles want 0", bad_cnt); n_err++; end
    n_cmp++;
    bus2.repeat_en = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;  bus.repeat_en = 1'b0;  bus.abort = 1'b0;
    bus2.start = 1'b0; bus2.repeat_en = 1'b0; bus2.abort = 1'b0;
    test_reset();
    test_single_pass();
    test_repeat();
    test_abort();
    test_min_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
